// File: rtl/riscv_pkg.sv
// Shared constants and helpers for the RISC-V fabric blocks.
// Only generic sizing lives here; channel-specific types stay with their modules.
package riscv_pkg;

    localparam int XLEN = 32;

    // Index width for n channels; a single channel still gets one bit.
    function automatic int srcw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the first requester found starting at ptr wins.
// It is kept free of any handshake logic so other multi-master blocks can reuse it.
module rr_arbiter
    import riscv_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = srcw(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic found;

    // The first pass covers channels ptr..N-1 and the second covers 0..ptr-1, which gives the circular search order.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 round-robin arbitrating mux with a single full-throughput output register.
// The only state is the output beat and the round-robin pointer.
module arb_mux
    import riscv_pkg::*;
#(
    parameter  int WIDTH = XLEN,
    parameter  int N     = 4,
    localparam int SRCW  = srcw(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     in_valid,
    input  logic [WIDTH-1:0] in_data [N],
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SRCW-1:0]  out_src,
    input  logic             out_ready
);

    logic [SRCW-1:0] ptr;
    logic [N-1:0]    grant;
    logic [SRCW-1:0] grant_idx;
    logic            can_accept;
    logic            in_fire;
    logic [SRCW-1:0] ptr_next;

    rr_arbiter #(
        .N  (N),
        .IW (SRCW)
    ) u_arb (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Reset masks in_ready so that nothing is accepted in a cycle that is about to be discarded.
    always_comb begin
        can_accept = !out_valid || out_ready;
        in_ready   = (!reset && can_accept) ? grant : '0;
        in_fire    = |in_ready;
        ptr_next   = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end

    // If the beat is not refilled, draining it only drops out_valid, and data and source keep their values.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant_idx];
            out_src   <= grant_idx;
            ptr       <= ptr_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: directed scenarios plus a randomized run against a behavioural model.
// A second instance with N=1 and WIDTH=8 covers the degenerate register-slice case.
module tb_arb_mux;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;
    localparam int W1 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [N-1:0]  in_valid;
    logic [W-1:0]  in_data [N];
    logic [N-1:0]  in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_src;
    logic          out_ready;

    logic [0:0]    in_valid1;
    logic [W1-1:0] in_data1 [1];
    logic [0:0]    in_ready1;
    logic          out_valid1;
    logic [W1-1:0] out_data1;
    logic [0:0]    out_src1;
    logic          out_ready1;

    int checks = 0;
    int fails  = 0;

    arb_mux #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    arb_mux #(.WIDTH(W1), .N(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid1),
        .in_data   (in_data1),
        .in_ready  (in_ready1),
        .out_valid (out_valid1),
        .out_data  (out_data1),
        .out_src   (out_src1),
        .out_ready (out_ready1)
    );

    // Reference model: output slot plus the channel that the next search starts from.
    bit          mv;
    logic [W-1:0] md;
    int          ms;
    int          mp;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        if (reset || !(!mv || out_ready)) return '0;
        g = pick(in_valid, mp);
        if (g < 0) return '0;
        return N'(1) << g;
    endfunction

    always @(posedge clk) begin : model_step
        int g;
        if (reset) begin
            mv = 1'b0; md = '0; ms = 0; mp = 0;
        end else begin
            g = pick(in_valid, mp);
            if ((!mv || out_ready) && g >= 0) begin
                mv = 1'b1; md = in_data[g]; ms = g; mp = (g + 1) % N;
            end else if (out_ready) begin
                mv = 1'b0;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i] = $urandom;
        settle();
        checks++;
        if (in_ready !== 4'b0000) begin fails++; $display("[TB] FAIL reset_in_ready_pre: got %b expected %b", in_ready, 4'b0000); end
        for (int c = 0; c < 2; c++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
            checks++;
            if (out_data !== 32'h0) begin fails++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
            checks++;
            if (out_src !== 2'd0) begin fails++; $display("[TB] FAIL reset_out_src: got %0d expected 0", out_src); end
            checks++;
            if (in_ready !== 4'b0000) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 0000", in_ready); end
        end
        reset = 1'b0;
    endtask

    task automatic test_fairness();
        in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i] = 32'hA0 + i;
        for (int k = 0; k < 5; k++) begin
            settle();
            checks++;
            if (in_ready !== 4'(1 << (k % 4))) begin fails++; $display("[TB] FAIL fair_in_ready[%0d]: got %b expected %b", k, in_ready, 4'(1 << (k % 4))); end
            cycle();
            checks++;
            if (out_valid !== 1'b1 || out_src !== 2'(k % 4) || out_data !== 32'hA0 + (k % 4)) begin
                fails++;
                $display("[TB] FAIL fair_beat[%0d]: got v=%b src=%0d data=%h expected v=1 src=%0d data=%h",
                         k, out_valid, out_src, out_data, k % 4, 32'hA0 + (k % 4));
            end
        end
    endtask

    task automatic test_backpressure();
        in_valid = 4'b0100; in_data[2] = 32'hDEADBEEF; out_ready = 1'b1;
        settle();
        checks++;
        if (in_ready !== 4'b0100) begin fails++; $display("[TB] FAIL bp_load_ready: got %b expected 0100", in_ready); end
        cycle();
        out_ready = 1'b0; in_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N; i++) if (i != 2) in_data[i] = $urandom;
            settle();
            checks++;
            if (in_ready !== 4'b0000) begin fails++; $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0000", c, in_ready); end
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_src !== 2'd2) begin
                fails++;
                $display("[TB] FAIL bp_hold[%0d]: got v=%b data=%h src=%0d expected v=1 data=deadbeef src=2", c, out_valid, out_data, out_src);
            end
            cycle();
        end
        out_ready = 1'b1; in_data[3] = 32'h33330003;
        settle();
        checks++;
        if (in_ready !== 4'b1000) begin fails++; $display("[TB] FAIL bp_release_ready: got %b expected 1000", in_ready); end
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 32'h33330003) begin
            fails++;
            $display("[TB] FAIL bp_release_beat: got v=%b src=%0d data=%h expected v=1 src=3 data=33330003", out_valid, out_src, out_data);
        end
    endtask

    task automatic test_sparse_wrap();
        out_ready = 1'b1; in_valid = 4'b0100;
        cycle();
        in_valid = 4'b0010; in_data[1] = 32'h11;
        settle();
        checks++;
        if (in_ready !== 4'b0010) begin fails++; $display("[TB] FAIL sparse_ready: got %b expected 0010", in_ready); end
        cycle();
        checks++;
        if (out_src !== 2'd1 || out_data !== 32'h11) begin fails++; $display("[TB] FAIL sparse_beat: got src=%0d data=%h expected src=1 data=11", out_src, out_data); end
        in_valid = 4'b1001;
        settle();
        checks++;
        if (in_ready !== 4'b1000) begin fails++; $display("[TB] FAIL wrap_ready: got %b expected 1000", in_ready); end
        cycle();
        checks++;
        if (out_src !== 2'd3) begin fails++; $display("[TB] FAIL wrap_beat: got src=%0d expected 3", out_src); end
        in_valid = 4'b1111;
        settle();
        checks++;
        if (in_ready !== 4'b0001) begin fails++; $display("[TB] FAIL wrap_ptr0: got %b expected 0001", in_ready); end
        cycle();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1; in_valid = 4'b0010; in_data[1] = 32'h11111111;
        cycle();
        out_ready = 1'b0; in_valid = 4'b0000;
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h11111111) begin fails++; $display("[TB] FAIL mid_held: got v=%b data=%h expected v=1 data=11111111", out_valid, out_data); end
        reset = 1'b1; in_valid = 4'b1111;
        settle();
        checks++;
        if (in_ready !== 4'b0000) begin fails++; $display("[TB] FAIL mid_reset_ready: got %b expected 0000", in_ready); end
        cycle();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0) begin
            fails++;
            $display("[TB] FAIL mid_after_reset: got v=%b data=%h src=%0d expected v=0 data=0 src=0", out_valid, out_data, out_src);
        end
        out_ready = 1'b1;
        settle();
        checks++;
        if (in_ready !== 4'b0001) begin fails++; $display("[TB] FAIL mid_first_grant: got %b expected 0001", in_ready); end
        cycle();
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 49) == 0);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) in_data[i] = $urandom;
            settle();
            er = exp_ready();
            checks++;
            if (in_ready !== er) begin fails++; $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", c, in_ready, er); end
            cycle();
            checks++;
            if (out_valid !== mv || (mv && (out_data !== md || int'(out_src) != ms))) begin
                fails++;
                $display("[TB] FAIL rand_out[%0d]: got v=%b data=%h src=%0d expected v=%b data=%h src=%0d",
                         c, out_valid, out_data, out_src, mv, md, ms);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic          pv;
        logic [W1-1:0] pd;
        out_ready1 = 1'b1;
        for (int k = 0; k < 24; k++) begin
            in_valid1   = 1'((k % 3) != 2);
            in_data1[0] = 8'($urandom);
            pv = in_valid1[0];
            pd = in_data1[0];
            settle();
            checks++;
            if (in_ready1 !== in_valid1) begin fails++; $display("[TB] FAIL single_ready[%0d]: got %b expected %b", k, in_ready1, in_valid1); end
            cycle();
            checks++;
            if (out_valid1 !== pv || out_src1 !== 1'b0 || (pv && out_data1 !== pd)) begin
                fails++;
                $display("[TB] FAIL single_out[%0d]: got v=%b src=%0d data=%h expected v=%b src=0 data=%h", k, out_valid1, out_src1, out_data1, pv, pd);
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = '0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) in_data[i] = '0;
        in_valid1 = '0; in_data1[0] = '0; out_ready1 = 1'b0;
        #2;
        test_reset();
        test_fairness();
        test_backpressure();
        test_sparse_wrap();
        test_reset_mid();
        test_random();
        test_single();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each channel and of the output.
REQ-002 SHALL have parameter N, default 4, number of input channels (legal range 1..16).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  N  per-channel request, bit i = channel i.
REQ-006 SHALL have port in_data  input  N x WIDTH  per-channel payload, unpacked array indexed by channel.
REQ-007 SHALL have port in_ready  output  N  per-channel accept, one-hot or zero.
REQ-008 SHALL have port out_valid  output  1  output register holds a beat.
REQ-009 SHALL have port out_data  output  WIDTH  registered payload.
REQ-010 SHALL have port out_src  output  SRCW  index of the channel that supplied out_data; SRCW = max(1, clog2(N)).
REQ-011 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-012 SHALL transfer an input beat on channel i only in a cycle where in_valid[i] and in_ready[i] are both 1.
REQ-013 SHALL transfer an output beat only in a cycle where out_valid and out_ready are both 1.
REQ-014 SHALL define can_accept = !out_valid | out_ready (single output register, full throughput, one beat per cycle).
REQ-015 SHALL compute grant combinationally from in_valid and round-robin pointer ptr only; grant never depends on out_ready or in_data.
REQ-016 SHALL grant the first channel with in_valid set, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-017 SHALL drive in_ready = grant when can_accept, else all zero.
REQ-018 SHALL, on an input transfer from channel g, load out_data <= in_data[g], out_src <= g, out_valid <= 1, ptr <= (g+1) mod N, all visible the next cycle (latency 1).
REQ-019 SHALL, on an output transfer with no simultaneous input transfer, clear out_valid next cycle; out_data and out_src keep their values.
REQ-020 SHALL, on simultaneous output and input transfer, keep out_valid = 1 and present the new beat next cycle, with no bubble.
REQ-021 SHALL hold out_data, out_src and out_valid stable while out_valid = 1 and out_ready = 0; in_ready SHALL be all zero then.
REQ-022 SHALL leave ptr unchanged in any cycle without an input transfer, including when no in_valid bit is set.
REQ-023 SHALL wrap ptr from N-1 to 0; with N=1, ptr is constant 0 and the block degenerates to a one-stage register slice.
REQ-024 SHALL ignore in_data of channels not transferring in the current cycle.

Reset
REQ-025 SHALL, when reset = 1 at a rising edge, set out_valid = 0, out_data = 0, out_src = 0, ptr = 0, with reset taking priority over any transfer in that cycle.
REQ-026 SHALL discard a held beat on reset mid-operation; in_ready SHALL be all zero during any cycle in which reset is asserted.

Structure
REQ-027 SHALL place the default width constant (XLEN = 32) and the helper for SRCW in the shared package riscv_pkg; no channel-specific typedefs live there.
REQ-028 SHALL implement grant selection in one sub-module rr_arbiter (inputs req[N], ptr; output one-hot grant[N] and encoded index), reused by future multi-master blocks.
REQ-029 SHALL contain only one register stage (out_valid, out_data, out_src, ptr); no other storage.

Verification
REQ-030 SHALL verify reset: hold reset 2 cycles with in_valid = 4'b1111 -> out_valid = 0, out_data = 0, out_src = 0, in_ready = 0 during reset.
REQ-031 SHALL verify fairness: N=4, in_valid = 4'b1111 constant, out_ready = 1, in_data[i] = 32'hA0+i -> out_src sequence 0,1,2,3,0 on consecutive cycles, out_data 32'hA0,A1,A2,A3,A0.
REQ-032 SHALL verify backpressure: beat 32'hDEADBEEF from ch 2 held, out_ready = 0 for 5 cycles -> out_data/out_src stable at 32'hDEADBEEF/2, in_ready = 0, ptr unchanged; out_ready = 1 -> next granted channel is 3 if requesting.
REQ-033 SHALL verify sparse request and wrap: ptr = 3, in_valid = 4'b0010 -> grant ch 1, ptr becomes 2; then in_valid = 4'b1001 -> grant ch 3, ptr wraps to 0.
REQ-034 SHALL verify reset mid-operation: out_valid = 1 with out_ready = 0, assert reset 1 cycle -> out_valid = 0 next cycle, held beat never transferred, first post-reset grant starts search at ch 0.
REQ-035 SHALL verify N=1, WIDTH=8: in_valid toggling with out_ready = 1 -> out_data follows in_data with 1-cycle latency, out_src = 0 always.
